pad_frame_readout_buffer: RTL
=============================

// Module: pad_frame_readout_buffer
// PURPOSE
//  Downstream consumer of the pad-data deserialiser/checker path.
//  Captures each 116-bit pad frame and stamps it with a 12-bit clk160 timestamp.
//  Buffers frames in a FIFO and streams each frame out as four 32-bit words
//  over a valid/ready interface to the readout/DAQ logic.
// PARAMETERS
//  FIFO_AW     4   log2 of FIFO depth in frames (depth = 16 at default)
//  DROP_CNT_W  16  width of the saturating dropped-frame counter
// PORTS
//  clk160         in   1           system clock; all logic on its rising edge
//  reset          in   1           async active-high reset; clears all state
//  pad_data_in    in   116         pad frame from the deserialiser
//  pad_data_valid in   1           single-cycle strobe, pad_data_in valid
//  linked         in   1           link-lock status from the pad checker
//  m_data         out  32          output word
//  m_valid        out  1           m_data valid
//  m_ready        in   1           downstream accepts the word when m_valid&&m_ready
//  m_sof          out  1           first word of a frame (qualified by m_valid)
//  m_eof          out  1           last word of a frame (qualified by m_valid)
//  fifo_count     out  FIFO_AW+1   frames held in FIFO; excludes the frame being sent
//  fifo_full      out  1           FIFO holds 2**FIFO_AW frames
//  drop_cnt       out  DROP_CNT_W  frames dropped on full; saturates at all-ones
// BEHAVIOUR
//  Reset values: all outputs, pointers, counters, timestamp and FSM state are 0; FSM in IDLE.
//  Timestamp ts: free-running 12-bit counter, +1 every cycle, wraps 4095->0.
//  Write condition: pad_data_valid && linked at an edge.
//   - Not full: push {ts, pad_data_in} (128 bits). ts is the value in the strobe cycle.
//   - Full: no push; drop_cnt += 1 (saturating).
//   - fifo_full is evaluated before any pop in the same cycle. A write is dropped
//     even if a pop occurs in that same cycle.
//   - linked==0: strobe ignored; no push and no drop count.
//  Output FSM has two states, IDLE and SEND, with a 2-bit word index idx.
//   - IDLE: if FIFO non-empty, pop the head into the 128-bit frame register,
//     set idx=0, go to SEND. m_valid rises on the edge after the pop decision.
//   - SEND: m_valid=1. m_data = frame[127-32*idx -: 32], so word0 carries ts + pad[115:96].
//     m_sof = (idx==0); m_eof = (idx==3).
//   - Handshake: the word is held stable while m_valid && !m_ready.
//     On m_valid && m_ready, idx advances by 1.
//   - At idx==3 with the handshake: if FIFO non-empty, pop and load the next frame
//     with idx=0 and stay in SEND (back-to-back, no idle cycle). Otherwise go to IDLE.
//  Latency: a strobe at edge N makes the FIFO non-empty after N. Load happens at N+1.
//   First word is valid after N+1. With m_ready tied high, a frame takes 4 cycles.
//  Simultaneous push and pop in one cycle: fifo_count unchanged.
//  Pointers are FIFO_AW+1 bits and wrap naturally.
//   full  = pointers equal except MSB; empty = pointers equal.
//  Mid-operation reset: async clear. The partially sent frame is lost and
//   m_valid drops immediately. No partial frame is resumed after reset.
//  linked falling mid-frame: the frame in progress and already buffered frames
//   are still drained; only new captures stop.
// TESTING
//  1. Reset, linked=1, one strobe pad=116'h1_2345...(known), ts=5, m_ready=1
//     -> 4 words, word0=={12'd5,pad[115:96]}, sof on word0, eof on word3, first m_valid 2 edges after strobe.
//  2. m_ready=0, 20 strobes -> fifo_count=16, fifo_full=1.
//     (One frame may sit in the SEND register; if so fifo_count=16 after 17 captures.)
//     drop_cnt = 20 - captured; m_data held constant throughout.
//  3. m_ready toggling 1/0 randomly, 3 frames -> 12 words in order, no duplication or loss, sof/eof correct.
//  4. Strobe with linked=0 -> no output, fifo_count=0, drop_cnt=0.
//  5. Preset ts near wrap (strobe at ts=4095 then next cycle) -> word0 ts fields 4095 then 0.
//  6. Assert reset during word1 of a frame -> m_valid=0 at once, fifo_count=0, drop_cnt=0.
//     First post-reset frame starts with sof.

Source files
------------

// File: rtl/pad_frame_readout_buffer.sv
// pad_frame_readout_buffer
//   Captures 116-bit pad frames from the deserialiser/checker path and stamps
//   each one with a 12-bit clk160 timestamp. Stamped frames (128 bits) are
//   buffered in a FIFO and streamed to the readout logic as four 32-bit words
//   over a valid/ready interface. Word 0 carries {ts, pad[115:96]}.
//
// Ports
//   clk160         : system clock, rising edge
//   reset          : asynchronous active-high reset, clears all state
//   pad_data_in    : 116-bit pad frame
//   pad_data_valid : single-cycle strobe qualifying pad_data_in
//   linked         : link-lock status; strobes are ignored while low
//   m_data         : output word
//   m_valid        : m_data valid
//   m_ready        : downstream accepts a word when m_valid && m_ready
//   m_sof / m_eof  : first / last word of a frame
//   fifo_count     : frames waiting in the FIFO (excludes the frame being sent)
//   fifo_full      : FIFO holds 2**FIFO_AW frames
//   drop_cnt       : saturating count of frames dropped on a full FIFO
module pad_frame_readout_buffer #(
  parameter int FIFO_AW    = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk160,
  input  logic                  reset,
  input  logic [115:0]          pad_data_in,
  input  logic                  pad_data_valid,
  input  logic                  linked,
  output logic [31:0]           m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic [FIFO_AW:0]      fifo_count,
  output logic                  fifo_full,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state, state_next;

  logic [11:0]        ts;
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic [127:0]       mem [DEPTH];
  logic [127:0]       frame;
  logic [1:0]         idx;

  logic fifo_empty;
  logic capture;
  logic push;
  logic drop;
  logic pop;
  logic word_accept;
  logic last_word;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;

  // Full is judged on the registered pointers, so a write in the same cycle
  // as a pop from a full FIFO is still dropped.
  assign capture     = pad_data_valid && linked;
  assign push        = capture && !fifo_full;
  assign drop        = capture && fifo_full;
  assign word_accept = (state == SEND) && m_ready;
  assign last_word   = (idx == 2'd3);

  // ---- timestamp, FIFO pointers and drop counter ----
  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      ts       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      ts <= ts + 12'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // ---- frame storage (no reset: contents are only read behind the pointers) ----
  always_ff @(posedge clk160) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {ts, pad_data_in};
  end

  // ---- send register and word index ----
  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      frame <= '0;
      idx   <= '0;
    end else if (pop) begin
      frame <= mem[rd_ptr[FIFO_AW-1:0]];
      idx   <= '0;
    end else if (word_accept) begin
      idx <= idx + 2'd1;
    end
  end

  // ---- output FSM: state register ----
  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---- output FSM: next state ----
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!fifo_empty) state_next = SEND;
      SEND: if (word_accept && last_word && fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- output FSM: outputs ----
  // A pop either starts a frame from IDLE or chains the next frame directly
  // after the last word handshake, so back-to-back frames have no gap.
  always_comb begin
    m_valid = 1'b0;
    m_sof   = 1'b0;
    m_eof   = 1'b0;
    pop     = 1'b0;
    m_data  = frame[127:96];
    case (idx)
      2'd0:    m_data = frame[127:96];
      2'd1:    m_data = frame[95:64];
      2'd2:    m_data = frame[63:32];
      default: m_data = frame[31:0];
    endcase
    case (state)
      IDLE: pop = !fifo_empty;
      SEND: begin
        m_valid = 1'b1;
        m_sof   = (idx == 2'd0);
        m_eof   = last_word;
        pop     = word_accept && last_word && !fifo_empty;
      end
      default: pop = 1'b0;
    endcase
  end

endmodule
